// File: rtl/pc_sequencer_pkg.sv
// definitions: shared sequencer state encoding and default PC width.
package definitions;
  localparam int PC_W_DEFAULT = 10;
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEMWAIT, HALTED} seq_state_t;
endpackage

// File: rtl/pc_sequencer_next.sv
// pc_next_calc: next-PC adder with sign-extended branch/jump offset.
module pc_next_calc #(
  parameter int PC_W = 10
) (
  input  logic [PC_W-1:0] pc,
  input  logic [8:0]      offset,
  input  logic            take,
  input  logic            inc,
  output logic [PC_W-1:0] next_pc
);
  logic [PC_W-1:0] off_ext;
  assign off_ext = PC_W'($signed(offset));
  assign next_pc = take ? pc + off_ext : inc ? pc + 1'b1 : pc;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute controller owning the PC and retired-instruction count.
module pc_sequencer
  import definitions::*;
#(
  parameter int PC_W  = PC_W_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic             IsJump,
  input  logic             IsBranch,
  input  logic             BranchCond,
  input  logic [8:0]       Offset,
  input  logic             MemReq,
  input  logic             MemDone,
  output logic [PC_W-1:0]  PC,
  output logic             InstValid,
  output logic             MemStart,
  output logic             Done,
  output logic [CNT_W-1:0] InstCount
);
  seq_state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic done_q, done_d, clr, take, inc;
  pc_next_calc #(.PC_W(PC_W)) u_next (
    .pc(pc_q), .offset(Offset), .take(take), .inc(inc), .next_pc(pc_nxt)
  );
  always_comb begin
    state_d   = state_q;
    clr       = 1'b0;
    take      = 1'b0;
    inc       = 1'b0;
    InstValid = 1'b0;
    MemStart  = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        clr     = Start;
        state_d = Start ? FETCH : state_q;
      end
      FETCH: state_d = EXEC;
      EXEC: begin
        MemStart  = !Halt && MemReq;
        InstValid = !Halt && !MemReq;
        take      = InstValid && (IsJump || (IsBranch && BranchCond));
        inc       = InstValid;
        state_d   = Halt ? HALTED : MemReq ? MEMWAIT : FETCH;
      end
      MEMWAIT: begin
        InstValid = MemDone;
        inc       = MemDone;
        state_d   = MemDone ? FETCH : MEMWAIT;
      end
      default: state_d = IDLE;
    endcase
    pc_d   = clr ? '0 : pc_nxt;
    cnt_d  = clr ? '0 : (InstValid && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    done_d = state_d == HALTED;
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end
  assign PC        = pc_q;
  assign InstCount = cnt_q;
  assign Done      = done_q;
endmodule
